sobel_window_gen: RTL

- Upstream feeder of the Sobel edge-detection core.
- Accepts a raster-order pixel stream from the memory-read stage and keeps two line buffers.
- Emits one complete 3x3 neighbourhood per interior pixel to the gradient/magnitude stage.
- Started per frame by the same start/width/length controls the top level receives.

---
 rtl/sobel_pkg.sv | 20 ++
 rtl/sobel_line_buffer.sv | 26 ++
 rtl/sobel_window_gen.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/sobel_pkg.sv
// Shared constants and types for the Sobel window generator.
package sobel_pkg;

  localparam int PIXEL_W   = 8;
  localparam int DIM_W     = 12;
  localparam int MAX_WIDTH = 640;

  typedef logic [PIXEL_W-1:0] pixel_t;

  // 3x3 neighbourhood, [row][column], row 0 = top, column 0 = left.
  typedef pixel_t window_t [3][3];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/sobel_line_buffer.sv
// Single-port line buffer: one combinational read and one write per cycle at
// the same address. The read returns the old contents (read-before-write).
module sobel_line_buffer #(
  parameter int DEPTH  = 640,
  parameter int DATA_W = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write the new column sample; the read below still sees the previous line.
  // NOTE: the storage array has no reset; stale contents are never emitted
  // because windows only form once two full lines have been written.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/sobel_window_gen.sv
// Sobel window generator: turns a raster pixel stream into one 3x3
// neighbourhood per interior pixel, using two line buffers (packed into one
// double-width memory) and a 3x3 shift array.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int PIXEL_W   = sobel_pkg::PIXEL_W,
  parameter int MAX_WIDTH = sobel_pkg::MAX_WIDTH,
  parameter int DIM_W     = sobel_pkg::DIM_W
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 start,
  input  logic [DIM_W-1:0]     width,
  input  logic [DIM_W-1:0]     length,
  input  logic [PIXEL_W-1:0]   pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [9*PIXEL_W-1:0] win,
  output logic                 win_valid,
  input  logic                 win_ready,
  output logic [DIM_W-1:0]     win_row,
  output logic [DIM_W-1:0]     win_col,
  output logic                 busy,
  output logic                 frame_done,
  output logic                 dim_err
);

  localparam int ADDR_W = $clog2(MAX_WIDTH);

  state_t             r_state;
  state_t             w_next_state;
  logic [DIM_W-1:0]   r_wid_m1;
  logic [DIM_W-1:0]   r_len_m1;
  logic [DIM_W-1:0]   r_col;
  logic [DIM_W-1:0]   r_row;
  logic [DIM_W-1:0]   r_win_row;
  logic [DIM_W-1:0]   r_win_col;
  logic               r_win_valid;
  logic               r_last_acc;
  logic               r_dim_err;
  logic [PIXEL_W-1:0] r_sh [3][3];

  logic               w_start_ok;
  logic               w_bad_dims;
  logic               w_win_free;
  logic               w_accept;
  logic               w_last_pix;
  logic               w_load_win;
  logic [PIXEL_W-1:0] w_lb0;
  logic [PIXEL_W-1:0] w_lb1;
  logic [2*PIXEL_W-1:0] w_lb_rd;
  logic [2*PIXEL_W-1:0] w_lb_wr;

  assign w_start_ok = (r_state == IDLE) && start;
  assign w_bad_dims = (width < DIM_W'(3)) || (length < DIM_W'(3)) ||
                      (width > DIM_W'(MAX_WIDTH));
  assign w_win_free = !r_win_valid || win_ready;
  assign w_accept   = pix_valid && pix_ready;
  assign w_last_pix = (r_row == r_len_m1) && (r_col == r_wid_m1);
  // Columns 0 and 1 and rows 0 and 1 only prime the shift array and line buffers.
  assign w_load_win = w_accept && (r_row >= DIM_W'(2)) && (r_col >= DIM_W'(2));

  // Upper half holds the line two rows up, lower half the line one row up.
  assign {w_lb1, w_lb0} = w_lb_rd;
  assign w_lb_wr        = {w_lb0, pix_in};

  sobel_line_buffer #(
    .DEPTH  (MAX_WIDTH),
    .DATA_W (2*PIXEL_W),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk     (clk),
    .i_we    (w_accept),
    .i_addr  (r_col[ADDR_W-1:0]),
    .i_wdata (w_lb_wr),
    .o_rdata (w_lb_rd)
  );

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every register in
  // the design samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (n_rst) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next-state logic; RUN ends once the final window has left the output register.
  // NOTE: defaulting w_next_state first keeps every path assigned, so no latch.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = w_bad_dims ? ERR : RUN;
      RUN:     if (r_last_acc && w_win_free) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      ERR:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    busy       = (r_state != IDLE);
    frame_done = (r_state == DONE) || (r_state == ERR);
    pix_ready  = (r_state == RUN) && w_win_free && !r_last_acc;
  end

  // Frame dimensions, raster counters, error flag and output window handshake.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      r_wid_m1    <= '0;
      r_len_m1    <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_last_acc  <= 1'b0;
      r_dim_err   <= 1'b0;
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
    end else begin
      if (w_start_ok) begin
        r_wid_m1   <= width - DIM_W'(1);
        r_len_m1   <= length - DIM_W'(1);
        r_col      <= '0;
        r_row      <= '0;
        r_last_acc <= 1'b0;
        r_dim_err  <= w_bad_dims;
      end else if (w_accept) begin
        if (r_col == r_wid_m1) begin
          r_col <= '0;
          r_row <= r_row + DIM_W'(1);
        end else begin
          r_col <= r_col + DIM_W'(1);
        end
        if (w_last_pix) r_last_acc <= 1'b1;
      end

      if (w_load_win) begin
        r_win_valid <= 1'b1;
        r_win_row   <= r_row - DIM_W'(1);
        r_win_col   <= r_col - DIM_W'(1);
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  // Shift the 3x3 array left one column per accepted pixel; new column enters right.
  always_ff @(posedge clk) begin
    if (n_rst) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          r_sh[i][j] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < 3; i++) begin
        r_sh[i][0] <= r_sh[i][1];
        r_sh[i][1] <= r_sh[i][2];
      end
      r_sh[0][2] <= w_lb1;
      r_sh[1][2] <= w_lb0;
      r_sh[2][2] <= pix_in;
    end
  end

  // Flatten the shift array: element k = 3*row + col at bits [k*PIXEL_W +: PIXEL_W].
  always_comb begin
    win = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        win[(3*i+j)*PIXEL_W +: PIXEL_W] = r_sh[i][j];
  end

  assign win_valid = r_win_valid;
  assign win_row   = r_win_row;
  assign win_col   = r_win_col;
  assign dim_err   = r_dim_err;

endmodule
